pwm_duty_meter: RTL and testbench

Measures the duty cycle and period of a PWM waveform, such as the 30/50/70/100 % outputs of the PWM generator, and reports them as numbers. It sits directly downstream of the PWM stage. It samples the waveform on the same base-rate tick that drives the generator, so measurements are in tick units: a 512-tick frame reads as period 512. It produces an integer percentage and a one-cycle `valid` strobe per completed PWM period, for use by logging, display or closed-loop logic.

---
 rtl/pwm_duty_meter.sv | 189 ++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period, high time and integer duty percentage of a
// PWM waveform sampled on a base-rate tick. A restoring divider turns each
// completed period into a percentage and strobes valid once per period.
module pwm_duty_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [6:0]       duty_pct,
    output logic             valid,
    output logic             timeout,
    output logic             overrun
);

    // Dividend is high_time*100, which needs 7 extra bits over the counters.
    localparam int                DVD_W   = CNT_W + 7;
    localparam int                IT_W    = $clog2(DVD_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_PRE = CNT_MAX - CNT_W'(1);
    localparam logic [IT_W-1:0]   IT_LAST = IT_W'(DVD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE
    } state_t;

    // Saturating increment used by both sample counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                                 input logic             inc);
        if (inc && (a != CNT_MAX)) begin
            return a + CNT_W'(1);
        end
        return a;
    endfunction

    // A percentage can never legitimately exceed 100; clamp defensively.
    function automatic logic [6:0] clamp_pct(input logic [DVD_W-1:0] q);
        if (q > DVD_W'(100)) begin
            return 7'd100;
        end
        return q[6:0];
    endfunction

    logic             sync1_q;
    logic             s_q;
    logic             prev_q;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] hi_cnt_q;

    state_t           state_q;
    logic [CNT_W-1:0] p_lat_q;
    logic [CNT_W-1:0] h_lat_q;
    logic [DVD_W-1:0] dvd_q;
    logic [CNT_W-1:0] rem_q;
    logic [IT_W-1:0]  iter_q;

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic [6:0]       duty_q;
    logic             valid_q;
    logic             timeout_q;
    logic             overrun_q;

    logic             rise;
    logic             sat_hit;
    logic [CNT_W:0]   trial;
    logic             qbit;
    logic [CNT_W-1:0] rem_d;
    logic [DVD_W-1:0] dvd_d;

    // Rising edge seen on this tick, and the tick on which per_cnt saturates.
    assign rise    = sample_en && !prev_q && s_q;
    assign sat_hit = sample_en && !rise && (per_cnt_q == CNT_PRE);

    // Two-flop synchroniser, free-running on every clock.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            s_q     <= sync1_q;
        end
    end

    // Edge history and period/high-time counters, advanced only on ticks.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            prev_q    <= 1'b0;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
        end else if (sample_en) begin
            prev_q <= s_q;
            if (rise) begin
                per_cnt_q <= CNT_W'(1);
                hi_cnt_q  <= CNT_W'(1);
            end else begin
                per_cnt_q <= sat_inc(per_cnt_q, 1'b1);
                hi_cnt_q  <= sat_inc(hi_cnt_q, s_q);
            end
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial = {rem_q, dvd_q[DVD_W-1]};
        qbit  = (trial >= {1'b0, p_lat_q});
        rem_d = CNT_W'(qbit ? (trial - {1'b0, p_lat_q}) : trial);
        dvd_d = {dvd_q[DVD_W-2:0], qbit};
    end

    // Measurement FSM with divider sequencing and registered result outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            p_lat_q   <= '0;
            h_lat_q   <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            iter_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (rise) begin
                timeout_q <= 1'b0;
            end
            unique case (state_q)
                IDLE, MEASURE: begin
                    if (rise) begin
                        if (state_q == MEASURE) begin
                            // Latch the completed period before the counters restart.
                            p_lat_q <= per_cnt_q;
                            h_lat_q <= hi_cnt_q;
                            dvd_q   <= DVD_W'(hi_cnt_q) * DVD_W'(100);
                            rem_q   <= '0;
                            iter_q  <= '0;
                            state_q <= DIVIDE;
                        end else begin
                            // First edge after idle: the partial period is discarded.
                            state_q <= MEASURE;
                        end
                    end else if (sat_hit) begin
                        // No edge for a full counter range: report the stuck level.
                        timeout_q <= 1'b1;
                        period_q  <= '0;
                        high_q    <= '0;
                        duty_q    <= s_q ? 7'd100 : 7'd0;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                DIVIDE: begin
                    if (rise) begin
                        overrun_q <= 1'b1;
                    end
                    rem_q  <= rem_d;
                    dvd_q  <= dvd_d;
                    iter_q <= iter_q + IT_W'(1);
                    if (iter_q == IT_LAST) begin
                        period_q <= p_lat_q;
                        high_q   <= h_lat_q;
                        duty_q   <= clamp_pct(dvd_d);
                        valid_q  <= 1'b1;
                        state_q  <= MEASURE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign duty_pct  = duty_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: a default-width instance for duty,
// latency, reset and overrun scenarios, and a 10-bit instance for timeout.
module tb_pwm_duty_meter;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_a = 1'b1, se_a = 1'b0, pwm_a = 1'b0;
    logic [15:0] per_a, hi_a;
    logic [6:0]  duty_a;
    logic        val_a, to_a, ovr_a;

    logic        rst_b = 1'b1, se_b = 1'b0, pwm_b = 1'b0;
    logic [9:0]  per_b, hi_b;
    logic [6:0]  duty_b;
    logic        val_b, to_b, ovr_b;

    pwm_duty_meter u_a (
        .clk_in(clk_in), .rst(rst_a), .sample_en(se_a), .pwm_in(pwm_a),
        .period(per_a), .high_time(hi_a), .duty_pct(duty_a),
        .valid(val_a), .timeout(to_a), .overrun(ovr_a)
    );

    pwm_duty_meter #(.CNT_W(10)) u_b (
        .clk_in(clk_in), .rst(rst_b), .sample_en(se_b), .pwm_in(pwm_b),
        .period(per_b), .high_time(hi_b), .duty_pct(duty_b),
        .valid(val_b), .timeout(to_b), .overrun(ovr_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Negedge index plus a log of every valid strobe from each instance.
    int   nc = 0;
    int   qa_nc[$], qa_per[$], qa_hi[$], qa_duty[$];
    int   a_wide = 0;
    logic val_a_d = 1'b0;
    int   vb_cnt = 0, vb_per = 0, vb_hi = 0, vb_duty = 0;

    always @(negedge clk_in) begin
        nc <= nc + 1;
        if (val_a === 1'b1) begin
            qa_nc.push_back(nc + 1);
            qa_per.push_back(int'(per_a));
            qa_hi.push_back(int'(hi_a));
            qa_duty.push_back(int'(duty_a));
        end
        if (val_a === 1'b1 && val_a_d === 1'b1) a_wide <= a_wide + 1;
        val_a_d <= val_a;
        if (val_b === 1'b1) begin
            vb_cnt  <= vb_cnt + 1;
            vb_per  <= int'(per_b);
            vb_hi   <= int'(hi_b);
            vb_duty <= int'(duty_b);
        end
    end

    int tick_nc;
    int edges[$];

    // One sample tick, gap cycles long; pwm level is set (optionally jittered) first.
    task automatic tick(input bit sel_b, input logic lvl, input int gap, input int jit);
        if (jit > 0) #(jit);
        if (sel_b) pwm_b = lvl; else pwm_a = lvl;
        repeat (gap - 1) @(negedge clk_in);
        if (sel_b) se_b = 1'b1; else se_a = 1'b1;
        #1 tick_nc = nc;
        @(negedge clk_in);
        se_a = 1'b0;
        se_b = 1'b0;
    endtask

    task automatic do_reset(input bit sel_b, input logic lvl);
        @(negedge clk_in);
        if (sel_b) begin rst_b = 1'b1; pwm_b = lvl; end
        else       begin rst_a = 1'b1; pwm_a = lvl; end
        repeat (3) @(negedge clk_in);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        qa_nc.delete(); qa_per.delete(); qa_hi.delete(); qa_duty.delete();
        edges.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    int hts[3] = '{154, 256, 358};
    int dts[3] = '{30, 50, 69};
    int dev;

    initial begin
        // Reset with the input held high.
        do_reset(0, 1'b1);
        check("rst_period",  per_a,  0);
        check("rst_high",    hi_a,   0);
        check("rst_duty",    duty_a, 0);
        check("rst_valid",   val_a,  0);
        check("rst_timeout", to_a,   0);
        check("rst_overrun", ovr_a,  0);
        repeat (10) tick(0, 1'b1, 24, 0);
        settle(2);
        check("rst_no_valid", qa_per.size(), 0);

        // Nominal 30/50/70 % frames of 512 ticks.
        do_reset(0, 1'b0);
        repeat (3) tick(0, 1'b0, 24, 0);
        for (int p = 0; p < 3; p++) begin
            tick(0, 1'b1, 24, 0);
            edges.push_back(tick_nc);
            repeat (hts[p] - 1) tick(0, 1'b1, 24, 0);
            repeat (512 - hts[p]) tick(0, 1'b0, 24, 0);
        end
        tick(0, 1'b1, 24, 0);
        edges.push_back(tick_nc);
        settle(30);
        check("nom_count", qa_per.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < qa_per.size()) begin
                check("nom_period",  qa_per[k],  512);
                check("nom_high",    qa_hi[k],   hts[k]);
                check("nom_duty",    qa_duty[k], dts[k]);
                check("nom_latency", qa_nc[k] - edges[k+1], 24);
            end
        end
        check("nom_valid_width", a_wide, 0);
        check("nom_timeout", to_a, 0);
        check("nom_overrun", ovr_a, 0);

        // Stuck-high input on the 10-bit instance.
        do_reset(1, 1'b1);
        repeat (1022) tick(1, 1'b1, 18, 0);
        settle(2);
        check("stk_timeout_early", to_b, 0);
        check("stk_valid_early", vb_cnt, 0);
        tick(1, 1'b1, 18, 0);
        settle(2);
        check("stk_timeout", to_b, 1);
        check("stk_valid_cnt", vb_cnt, 1);
        check("stk_period", vb_per, 0);
        check("stk_high", vb_hi, 0);
        check("stk_duty", vb_duty, 100);
        repeat (5) tick(1, 1'b1, 18, 0);
        repeat (4) tick(1, 1'b0, 18, 0);
        settle(2);
        check("stk_single_valid", vb_cnt, 1);
        check("stk_timeout_held", to_b, 1);
        tick(1, 1'b1, 18, 0);
        settle(1);
        check("stk_timeout_clear", to_b, 0);
        repeat (5) tick(1, 1'b1, 18, 0);
        repeat (4) tick(1, 1'b0, 18, 0);
        tick(1, 1'b1, 18, 0);
        settle(30);
        check("stk_rec_cnt", vb_cnt, 2);
        check("stk_rec_period", vb_per, 10);
        check("stk_rec_high", vb_hi, 6);
        check("stk_rec_duty", vb_duty, 60);

        // Reset in the middle of a divide.
        do_reset(0, 1'b0);
        repeat (3) tick(0, 1'b0, 24, 0);
        tick(0, 1'b1, 24, 0);
        repeat (4) tick(0, 1'b1, 24, 0);
        repeat (5) tick(0, 1'b0, 24, 0);
        tick(0, 1'b1, 24, 0);
        repeat (9) @(negedge clk_in);
        rst_a = 1'b1;
        pwm_a = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_a = 1'b0;
        settle(30);
        check("rmd_no_valid", qa_per.size(), 0);
        repeat (3) tick(0, 1'b0, 24, 0);
        tick(0, 1'b1, 24, 0);
        repeat (2) tick(0, 1'b1, 24, 0);
        settle(2);
        check("rmd_discard", qa_per.size(), 0);
        repeat (5) tick(0, 1'b0, 24, 0);
        tick(0, 1'b1, 24, 0);
        settle(30);
        check("rmd_count", qa_per.size(), 1);
        if (qa_per.size() > 0) begin
            check("rmd_period", qa_per[0], 8);
            check("rmd_high", qa_hi[0], 3);
            check("rmd_duty", qa_duty[0], 37);
        end

        // Overrun: ticks too close together with a 2-tick period.
        do_reset(0, 1'b0);
        check("ovr_reset", ovr_a, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1'b0, 5, 0);
            tick(0, 1'b1, 5, 0);
        end
        settle(1);
        check("ovr_set", ovr_a, 1);
        repeat (10) tick(0, 1'b0, 24, 0);
        settle(1);
        check("ovr_sticky", ovr_a, 1);
        do_reset(0, 1'b0);
        check("ovr_cleared", ovr_a, 0);

        // Input edges at random sub-cycle offsets, 7/20 duty.
        do_reset(0, 1'b0);
        repeat (2) tick(0, 1'b0, 24, 0);
        for (int p = 0; p < 21; p++) begin
            tick(0, 1'b1, 24, int'($urandom_range(1, 9)));
            repeat (6)  tick(0, 1'b1, 24, int'($urandom_range(1, 9)));
            repeat (13) tick(0, 1'b0, 24, int'($urandom_range(1, 9)));
        end
        settle(5);
        check("meta_count", qa_per.size(), 20);
        for (int k = 0; k < qa_per.size(); k++) begin
            dev = qa_duty[k] - 35;
            if (dev < 0) dev = -dev;
            check("meta_period", qa_per[k], 20);
            check("meta_duty_within_1", int'(dev <= 1), 1);
        end
        check("meta_valid_width", a_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
